generate_sinus: RTL and testbench
=================================

GENERATE_SINUS -- requirements
Module: generate_sinus

Interface
REQ-001 Parameters: none; all constants come from generate_sinus_pkg.
REQ-002 Clocking: one clock; reset is synchronous and active-low.
REQ-003 clk  input  1  rising-edge clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  synchronous active-low reset.
REQ-005 freq  input  16  unsigned phase-increment tuning word; output frequency = freq * f_clk / 65536.
REQ-006 signal  output  16  signed two's-complement sine sample, registered.

Function
REQ-007 The block SHALL hold a 16-bit unsigned phase accumulator, phase.
REQ-008 On each rising edge with rst_n=1, phase SHALL update to (phase + freq) mod 65536; wrap-around is silent.
REQ-009 On the same edge, signal SHALL load sine(phase), using the pre-update phase value; latency is one clock from phase to signal.
REQ-010 Table index: idx = phase[15:8], 256 points per period; phase[7:0] is ignored and there is no interpolation.
REQ-011 Quarter-wave ROM: Q[k] = round(32767*sin(2*pi*k/256)) for k = 0..64, 65 entries; Q[0]=0, Q[64]=32767.
REQ-012 Quadrant idx[7:6]=0 -> +Q[idx[5:0]].
REQ-013 Quadrant idx[7:6]=1 -> +Q[64-idx[5:0]].
REQ-014 Quadrant idx[7:6]=2 -> -Q[idx[5:0]].
REQ-015 Quadrant idx[7:6]=3 -> -Q[64-idx[5:0]].
REQ-016 Output range SHALL be -32767..+32767; -32768 SHALL never be produced.
REQ-017 freq is sampled every edge with no handshake; a change takes effect on the next edge and leaves no phase discontinuity.
REQ-018 With freq=0, phase SHALL hold, and signal SHALL hold a constant equal to sine(phase).

Reset
REQ-019 With rst_n=0 at a rising edge, phase SHALL load 0 and signal SHALL load 0, overriding any update.
REQ-020 Reset asserted mid-operation SHALL take effect at the next edge; on the first edge after release, signal SHALL load sine(0)=0 and phase SHALL load freq.

Structure
REQ-021 generate_sinus_pkg SHALL hold ACC_W=16, OUT_W=16, IDX_W=8, QROM_DEPTH=65 and AMPLITUDE=32767.
REQ-022 One sub-module, sine_quarter_rom, SHALL hold the combinational 65-entry table, with a 7-bit address in and a 16-bit value out.
REQ-023 Quadrant folding, negation, the accumulator and the output register SHALL reside in generate_sinus.

Verification
REQ-024 Reset: hold rst_n=0 for 3 edges with freq=1000 -> signal=0 and phase=0 throughout.
REQ-025 freq=16384 after reset release -> signal sequence 0, 32767, 0, -32767, repeating every 4 clocks.
REQ-026 freq=32768 -> signal constant 0 (Q[0] and -Q[0] alternate); phase alternates 0 and 32768.
REQ-027 Half-wave symmetry:
- stimulus: freq=256, run 512 clocks;
- required: signal[n+128] == -signal[n] and signal[n+64] == Q[64-idx] pattern;
- required: peak +32767 at n=65 after release.
REQ-028 freq=261:
- stimulus: run 1000 clocks, then set freq=0;
- required: waveform period about 251 clocks;
- required: after freq=0, signal frozen at its last value plus one update, with no glitch.
REQ-029 Mid-run reset: assert rst_n=0 for 1 edge during freq=261 -> next signal=0, and the sequence restarts exactly as from power-up.

Source files
------------

// File: rtl/generate_sinus_pkg.sv
// Shared constants, quadrant encoding and ROM address folding for the sine generator.
package generate_sinus_pkg;

    localparam int ACC_W      = 16;     // phase accumulator width
    localparam int OUT_W      = 16;     // signed sample width
    localparam int IDX_W      = 8;      // table index taken from the accumulator MSBs
    localparam int QROM_DEPTH = 65;     // quarter wave including both end points
    localparam int QROM_AW    = 7;      // enough to address entries 0..64
    localparam int AMPLITUDE  = 32767;  // full-scale peak, keeps -32768 unreachable

    // Quadrant of the 256-point period, from idx[7:6].
    typedef enum logic [1:0] {
        QUAD_RISE     = 2'd0,  // +Q[k]
        QUAD_FALL     = 2'd1,  // +Q[64-k]
        QUAD_NEG_RISE = 2'd2,  // -Q[k]
        QUAD_NEG_FALL = 2'd3   // -Q[64-k]
    } quadrant_e;

    // Mirror the in-quadrant offset for the falling quarters.
    function automatic logic [QROM_AW-1:0] fold_addr(input quadrant_e quad,
                                                     input logic [IDX_W-3:0] off);
        logic [QROM_AW-1:0] addr;
        addr = {1'b0, off};
        if (quad == QUAD_FALL || quad == QUAD_NEG_FALL)
            addr = QROM_AW'(QROM_DEPTH - 1) - {1'b0, off};
        return addr;
    endfunction

endpackage

// File: rtl/sine_quarter_rom.sv
// Combinational quarter-wave table: round(32767*sin(2*pi*k/256)), k = 0..64.
module sine_quarter_rom
    import generate_sinus_pkg::*;
(
    input  logic [QROM_AW-1:0] addr_i,
    output logic [OUT_W-1:0]   data_o
);

    // Table lookup; addresses beyond 64 never occur and return zero.
    always_comb begin
        data_o = '0;
        case (addr_i)
            7'd0:  data_o = 16'd0;     7'd1:  data_o = 16'd804;
            7'd2:  data_o = 16'd1608;  7'd3:  data_o = 16'd2410;
            7'd4:  data_o = 16'd3212;  7'd5:  data_o = 16'd4011;
            7'd6:  data_o = 16'd4808;  7'd7:  data_o = 16'd5602;
            7'd8:  data_o = 16'd6393;  7'd9:  data_o = 16'd7179;
            7'd10: data_o = 16'd7962;  7'd11: data_o = 16'd8739;
            7'd12: data_o = 16'd9512;  7'd13: data_o = 16'd10278;
            7'd14: data_o = 16'd11039; 7'd15: data_o = 16'd11793;
            7'd16: data_o = 16'd12539; 7'd17: data_o = 16'd13279;
            7'd18: data_o = 16'd14010; 7'd19: data_o = 16'd14732;
            7'd20: data_o = 16'd15446; 7'd21: data_o = 16'd16151;
            7'd22: data_o = 16'd16846; 7'd23: data_o = 16'd17530;
            7'd24: data_o = 16'd18204; 7'd25: data_o = 16'd18868;
            7'd26: data_o = 16'd19519; 7'd27: data_o = 16'd20159;
            7'd28: data_o = 16'd20787; 7'd29: data_o = 16'd21403;
            7'd30: data_o = 16'd22005; 7'd31: data_o = 16'd22594;
            7'd32: data_o = 16'd23170; 7'd33: data_o = 16'd23732;
            7'd34: data_o = 16'd24279; 7'd35: data_o = 16'd24811;
            7'd36: data_o = 16'd25329; 7'd37: data_o = 16'd25832;
            7'd38: data_o = 16'd26319; 7'd39: data_o = 16'd26790;
            7'd40: data_o = 16'd27245; 7'd41: data_o = 16'd27683;
            7'd42: data_o = 16'd28105; 7'd43: data_o = 16'd28510;
            7'd44: data_o = 16'd28898; 7'd45: data_o = 16'd29268;
            7'd46: data_o = 16'd29621; 7'd47: data_o = 16'd29956;
            7'd48: data_o = 16'd30273; 7'd49: data_o = 16'd30571;
            7'd50: data_o = 16'd30852; 7'd51: data_o = 16'd31113;
            7'd52: data_o = 16'd31356; 7'd53: data_o = 16'd31580;
            7'd54: data_o = 16'd31785; 7'd55: data_o = 16'd31971;
            7'd56: data_o = 16'd32137; 7'd57: data_o = 16'd32285;
            7'd58: data_o = 16'd32412; 7'd59: data_o = 16'd32521;
            7'd60: data_o = 16'd32609; 7'd61: data_o = 16'd32678;
            7'd62: data_o = 16'd32728; 7'd63: data_o = 16'd32757;
            7'd64: data_o = 16'd32767;
            default: data_o = '0;
        endcase
    end

endmodule

// File: rtl/generate_sinus.sv
// Phase-accumulator sine generator: 16-bit NCO, 256-point table folded from a quarter wave.
module generate_sinus
    import generate_sinus_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ACC_W-1:0]        freq,
    output logic signed [OUT_W-1:0] signal
);

    logic [ACC_W-1:0]        phase_q, phase_d;
    logic signed [OUT_W-1:0] signal_q, signal_d;
    logic [IDX_W-1:0]        idx;
    quadrant_e               quad;
    logic [QROM_AW-1:0]      rom_addr;
    logic [OUT_W-1:0]        rom_data;

    assign idx      = phase_q[ACC_W-1 -: IDX_W];
    assign quad     = quadrant_e'(idx[IDX_W-1 -: 2]);
    assign rom_addr = fold_addr(quad, idx[IDX_W-3:0]);

    sine_quarter_rom u_rom (
        .addr_i (rom_addr),
        .data_o (rom_data)
    );

    // Next phase wraps silently; the sample is taken from the pre-update phase.
    always_comb begin
        phase_d  = phase_q + freq;
        signal_d = $signed(rom_data);
        if (quad == QUAD_NEG_RISE || quad == QUAD_NEG_FALL)
            signal_d = -$signed(rom_data);
    end

    // Accumulator and output register, both cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_q  <= '0;
            signal_q <= '0;
        end else begin
            phase_q  <= phase_d;
            signal_q <= signal_d;
        end
    end

    assign signal = signal_q;

endmodule

// File: tb/tb_generate_sinus.sv
// Directed self-checking bench for generate_sinus.
module tb_generate_sinus;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [15:0]        freq;
    logic signed [15:0] signal;

    int checks   = 0;
    int failures = 0;

    int qtab [65] = '{
            0,   804,  1608,  2410,  3212,  4011,  4808,  5602,  6393,  7179,
         7962,  8739,  9512, 10278, 11039, 11793, 12539, 13279, 14010, 14732,
        15446, 16151, 16846, 17530, 18204, 18868, 19519, 20159, 20787, 21403,
        22005, 22594, 23170, 23732, 24279, 24811, 25329, 25832, 26319, 26790,
        27245, 27683, 28105, 28510, 28898, 29268, 29621, 29956, 30273, 30571,
        30852, 31113, 31356, 31580, 31785, 31971, 32137, 32285, 32412, 32521,
        32609, 32678, 32728, 32757, 32767};

    int run1 [1000];
    int s256 [513];

    generate_sinus dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .freq   (freq),
        .signal (signal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int sine_ref(input int ph);
        int idx;
        int off;
        idx = (ph >> 8) & 255;
        off = idx % 64;
        case (idx / 64)
            0:       return qtab[off];
            1:       return qtab[64 - off];
            2:       return -qtab[off];
            default: return -qtab[64 - off];
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic hold_reset(input int n, input string tag);
        rst_n = 1'b0;
        for (int i = 0; i < n; i++) begin
            step();
            check({tag, "_sig"}, signal, 0);
            check({tag, "_phase"}, int'(dut.phase_q), 0);
        end
        rst_n = 1'b1;
    endtask

    initial begin
        int ph;
        int up1;
        int up2;
        int minv;
        rst_n = 1'b0;
        freq  = 16'd1000;

        hold_reset(3, "rst_init");

        // quarter-period stepping
        freq = 16'd16384;
        for (int n = 0; n < 8; n++) begin
            int exp4 [4] = '{0, 32767, 0, -32767};
            step();
            check("f16384_sig", signal, exp4[n % 4]);
        end

        // half-period stepping: zero output, phase toggles
        hold_reset(1, "rst_f32k");
        freq = 16'd32768;
        for (int n = 0; n < 6; n++) begin
            step();
            check("f32768_sig", signal, 0);
            check("f32768_phase", int'(dut.phase_q), (n % 2 == 0) ? 32768 : 0);
        end

        // one table step per clock
        hold_reset(1, "rst_f256");
        freq = 16'd256;
        minv = 0;
        for (int n = 1; n <= 512; n++) begin
            step();
            s256[n] = signal;
            if (signal < minv) minv = signal;
        end
        check("f256_n1",   s256[1],   0);
        check("f256_n2",   s256[2],   804);
        check("f256_n33",  s256[33],  23170);
        check("f256_peak", s256[65],  32767);
        check("f256_n129", s256[129], 0);
        check("f256_n130", s256[130], -804);
        check("f256_n193", s256[193], -32767);
        check("f256_n256", s256[256], -804);
        check("f256_min",  minv,      -32767);
        for (int n = 1; n <= 384; n++)
            check("f256_halfsym", s256[n + 128], -s256[n]);
        for (int k = 0; k <= 64; k++)
            check("f256_fall", s256[k + 65], qtab[64 - k]);

        // slow irrational-ish tone against a phase model
        hold_reset(1, "rst_f261");
        freq = 16'd261;
        ph = 0;
        for (int n = 0; n < 1000; n++) begin
            step();
            run1[n] = signal;
            check("f261_sig", signal, sine_ref(ph));
            ph = (ph + 261) & 65535;
        end
        up1 = -1;
        up2 = -1;
        for (int n = 1; n < 1000; n++) begin
            if (run1[n - 1] < 0 && run1[n] >= 0) begin
                if (up1 < 0) up1 = n;
                else if (up2 < 0) up2 = n;
            end
        end
        check("f261_period", int'((up2 - up1) >= 250 && (up2 - up1) <= 252), 1);

        // freeze: one last update from phase 64392, then constant
        check("f261_end_phase", int'(dut.phase_q), 64392);
        freq = 16'd0;
        for (int n = 0; n < 5; n++) begin
            step();
            check("freeze_sig", signal, -4011);
            check("freeze_phase", int'(dut.phase_q), 64392);
        end

        // mid-run reset restarts the sequence exactly
        hold_reset(1, "rst_mid0");
        freq = 16'd261;
        for (int n = 0; n < 300; n++) begin
            step();
            check("mid_pre", signal, run1[n]);
        end
        hold_reset(1, "rst_mid");
        for (int n = 0; n < 300; n++) begin
            step();
            check("mid_post", signal, run1[n]);
        end
        check("mid_post_phase", int'(dut.phase_q), (300 * 261) & 65535);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
